gate_sweep_checker: RTL and testbench
=====================================

Name: gate_sweep_checker

Overview:
- Self-checking stimulus engine for N-input reduction gates. It replaces hand-written, fixed-delay truth-table sequences.
- It drives every input combination 0 to 2^N_IN-1 in ascending order and holds each one for HOLD_CYCLES clocks.
- On the last hold cycle it samples the DUT output and compares it against a golden reduction selected by op.
- It counts mismatches and reports pass/done. It is instantiated in gate-level benches and FPGA self-test wrappers.

Parameters:
- N_IN, 3, number of DUT inputs (legal 1..16).
- HOLD_CYCLES, 4, clocks each vector is held (legal 1..255).

Ports:
- clk  input  1  single clock; everything is sampled on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; ignored while busy.
- op  input  3  golden function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; 6 and 7 are treated as OR. Latched on accepted start.
- stim  output  N_IN  vector driven to the DUT inputs (bit 0 = last input, e.g. c).
- dut_out  input  1  DUT output (F).
- busy  output  1  high from the cycle after an accepted start until DONE is entered.
- done  output  1  level; high while in DONE.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  N_IN+1  saturating mismatch count.
- fail_vec  output  N_IN  first mismatching vector; 0 if there is none.

Behaviour:
- Reset values:
  - state=IDLE
  - stim=0, busy=0, done=0, pass=0
  - err_count=0, fail_vec=0
  - hold counter=0, latched op=OR
- FSM states: IDLE, DRIVE, DONE.
- IDLE, start=1: latch op, clear err_count and fail_vec, stim=0, hold=0, go to DRIVE. busy rises on the next edge.
- DRIVE:
  - hold increments every cycle.
  - When hold==HOLD_CYCLES-1, compare dut_out with expected(op,stim) in that same cycle.
  - On mismatch: increment err_count, saturating at 2^N_IN. If this is the first mismatch, capture stim into fail_vec.
  - Then set hold=0. If stim is all ones, go to DONE; otherwise stim=stim+1.
- DONE:
  - done=1, busy=0, pass=(err_count==0). stim holds its final all-ones value.
  - start=1 restarts exactly as from IDLE: done falls on the next edge.
- Timing: start accepted at edge t gives stim=0 from t+1. DONE is entered at edge t+2^N_IN*HOLD_CYCLES.
- HOLD_CYCLES=1: a vector is compared on every cycle and there is no idle gap.
- start while in DRIVE is ignored. A changing op mid-sweep has no effect.
- dut_out is compared only on the last hold cycle, so the DUT has HOLD_CYCLES-1 clocks of settle margin.
- stim has no wrap: the final vector is all ones and there is no overflow to 0.
- rst asserted mid-sweep returns to the reset values on the next edge. The partial count is discarded.
- rst and start in the same cycle: rst wins.
- Expected-value rules:
  - AND/OR/XOR are &stim, |stim, ^stim.
  - NAND/NOR/XNOR are their inversions.
  - For N_IN=1, AND/OR reduce to stim[0], and XOR also equals stim[0].

Optional Feature:
- Macro: SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatch moves the FSM to DONE on the same edge that records it. err_count=1 and pass=0; stim freezes at the failing vector.
- Undefined: the sweep always runs all 2^N_IN vectors and err_count reports every mismatch.

Decomposition:
- Package gate_sweep_pkg:
  - op encoding constants (OP_AND..OP_XNOR)
  - state enum (IDLE, DRIVE, DONE)
  - function golden_reduce(op, vector) returning 1 bit
- One sub-module, gate_sweep_golden: purely combinational, computes expected from op and stim. It is reused by future N-input gate benches.
- Counters and FSM stay in the top module.

Test Plan:
- N_IN=3, HOLD=4, op=OR, DUT=ideal OR:
  - done rises 32 cycles after start.
  - stim steps 000..111 every 4 cycles.
  - err_count=0, pass=1, fail_vec=0.
- N_IN=3, op=AND, DUT=OR: mismatches at vectors 001..110 give err_count=6, fail_vec=3'b001, pass=0.
- N_IN=4, HOLD=1, op=XNOR, DUT=stuck-at-0:
  - err_count=8 (even-parity vectors), fail_vec=0000, done after 16 cycles.
  - With SWEEP_STOP_ON_FAIL_EN: done 1 cycle after start, err_count=1, stim=0000.
- Reset mid-sweep: assert rst when stim=3'b101. Next cycle stim=0, busy=0, err_count=0, state IDLE. A later start runs a full clean sweep.
- start asserted at cycle 5 of a sweep, and op changed from OR to XOR during DRIVE: ignored, results identical to the OR-only run. Then start in DONE with op=NOR and DUT=NOR: done drops, new sweep, pass=1.
- Boundary: N_IN=1, HOLD=255, op=NAND, DUT=inverter: done after 510 cycles, pass=1, err_count width 2 bits.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep checker: op encoding, FSM states and
// the golden reduction used to predict an N-input gate's output.
package gate_sweep_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  localparam int MAX_N_IN = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

  // Only the low n bits of vec take part; unused upper bits are ignored so a
  // single 16-bit function serves every legal gate width.
  function automatic logic golden_reduce(input logic [2:0] op,
                                         input logic [MAX_N_IN-1:0] vec,
                                         input int n);
    logic r_and;
    logic r_or;
    logic r_xor;
    logic res;
    r_and = 1'b1;
    r_or  = 1'b0;
    r_xor = 1'b0;
    for (int i = 0; i < MAX_N_IN; i++) begin
      if (i < n) begin
        r_and = r_and & vec[i];
        r_or  = r_or  | vec[i];
        r_xor = r_xor ^ vec[i];
      end
    end
    case (op)
      OP_AND:  res = r_and;
      OP_OR:   res = r_or;
      OP_XOR:  res = r_xor;
      OP_NAND: res = ~r_and;
      OP_NOR:  res = ~r_or;
      OP_XNOR: res = ~r_xor;
      default: res = r_or;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_sweep_checker_golden.sv
// Combinational golden model: expected output of an N_IN-input reduction
// gate selected by op for the vector currently on vec.
module gate_sweep_golden
  import gate_sweep_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic [2:0]      op,
  input  logic [N_IN-1:0] vec,
  output logic            expected
);

  always_comb begin
    expected = golden_reduce(op, MAX_N_IN'(vec), N_IN);
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweep engine: drives every input vector 0..2^N_IN-1 for HOLD_CYCLES clocks,
// samples dut_out on the last hold cycle and counts mismatches.
// Optional macro SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int N_IN        = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  output logic [N_IN-1:0] stim,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_vec
);

  localparam logic [7:0]      HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]      HOLD_ONE  = 8'd1;
  localparam logic [N_IN-1:0] STIM_LAST = '1;
  localparam logic [N_IN-1:0] STIM_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE   = (N_IN + 1)'(1);
  localparam logic [N_IN:0]   ERR_MAX   = {1'b1, {N_IN{1'b0}}};

  sweep_state_t    state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [7:0]      hold_q, hold_d;
  logic [2:0]      op_q, op_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] fail_q, fail_d;

  logic expected;
  logic mismatch;
  logic stop_now;

  gate_sweep_golden #(.N_IN(N_IN)) u_golden (
    .op       (op_q),
    .vec      (stim_q),
    .expected (expected)
  );

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; that is what keeps this block from inferring latches.
  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    hold_d   = hold_q;
    op_d     = op_q;
    err_d    = err_q;
    fail_d   = fail_q;
    mismatch = 1'b0;
    stop_now = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          op_d    = op;
          err_d   = '0;
          fail_d  = '0;
          stim_d  = '0;
          hold_d  = '0;
        end
      end

      DRIVE: begin
        hold_d = hold_q + HOLD_ONE;
        if (hold_q == HOLD_LAST) begin
          hold_d   = '0;
          mismatch = (dut_out != expected);
          if (mismatch) begin
            if (err_q != ERR_MAX) err_d = err_q + ERR_ONE;
            // An empty count means this is the first mismatch of the sweep.
            if (err_q == '0) fail_d = stim_q;
          end
`ifdef SWEEP_STOP_ON_FAIL_EN
          stop_now = mismatch;
`else
          stop_now = 1'b0;
`endif
          if (stop_now || (stim_q == STIM_LAST)) begin
            state_d = DONE;
          end else begin
            stim_d = stim_q + STIM_ONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stim_q  <= '0;
      hold_q  <= '0;
      op_q    <= OP_OR;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      hold_q  <= hold_d;
      op_q    <= op_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    stim      = stim_q;
    busy      = (state_q == DRIVE);
    done      = (state_q == DONE);
    pass      = (state_q == DONE) && (err_q == '0);
    err_count = err_q;
    fail_vec  = fail_q;
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench for gate_sweep_checker: three instances cover the
// default geometry, HOLD_CYCLES=1 and the N_IN=1 / HOLD_CYCLES=255 boundary.
module tb_gate_sweep_checker;

`ifdef SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: N_IN=3, HOLD=4
  logic       start3 = 1'b0;
  logic [2:0] op3 = 3'd1;
  logic [2:0] stim3;
  logic       dut3;
  logic       busy3, done3, pass3;
  logic [3:0] err3;
  logic [2:0] fail3;
  logic [7:0] dut_tab3 = 8'hFE;
  assign dut3 = dut_tab3[stim3];

  // Instance B: N_IN=4, HOLD=1, stuck-at-0 DUT
  logic       start4 = 1'b0;
  logic [2:0] op4 = 3'd5;
  logic [3:0] stim4;
  logic       dut4;
  logic       busy4, done4, pass4;
  logic [4:0] err4;
  logic [3:0] fail4;
  assign dut4 = 1'b0;

  // Instance C: N_IN=1, HOLD=255, inverter DUT
  logic       start1 = 1'b0;
  logic [2:0] op1 = 3'd3;
  logic [0:0] stim1;
  logic       dut1;
  logic       busy1, done1, pass1;
  logic [1:0] err1;
  logic [0:0] fail1;
  assign dut1 = ~stim1[0];

  gate_sweep_checker #(.N_IN(3), .HOLD_CYCLES(4)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .op(op3), .stim(stim3),
    .dut_out(dut3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_vec(fail3));

  gate_sweep_checker #(.N_IN(4), .HOLD_CYCLES(1)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op4), .stim(stim4),
    .dut_out(dut4), .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .fail_vec(fail4));

  gate_sweep_checker #(.N_IN(1), .HOLD_CYCLES(255)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op1), .stim(stim1),
    .dut_out(dut1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fail1));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference gate behaviour from the count of ones in the active bits.
  function automatic bit ref_gold(input int op, input int v, input int n);
    int ones;
    ones = $countones(v & ((1 << n) - 1));
    case (op)
      0:       return ones == n;
      2:       return (ones % 2) == 1;
      3:       return ones != n;
      4:       return ones == 0;
      5:       return (ones % 2) == 0;
      default: return ones > 0;
    endcase
  endfunction

  typedef struct {
    logic [2:0] op;
    logic [7:0] tab;
    int         err;
    int         fail;
    bit         pass;
  } vec_t;

  vec_t vecs[8];

  // Full sweep on instance A. Expectations are for a complete sweep; the
  // stop-on-fail variant is derived from the first failing vector.
  task automatic run3(input string name, input logic [2:0] op, input logic [7:0] tab,
                      input int glitch_at, input int err_full, input int fail_v,
                      input bit exp_pass);
    int k;
    int bad;
    int exp_err;
    int exp_cycles;
    int exp_stim;
    bit stopped;
    stopped    = STOP && (err_full > 0);
    exp_err    = stopped ? 1 : err_full;
    exp_cycles = stopped ? (fail_v + 1) * 4 : 32;
    exp_stim   = stopped ? fail_v : 7;
    dut_tab3   = tab;
    @(negedge clk);
    op3    = op;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    check({name, "_busy_rise"}, busy3, 1);
    check({name, "_done_fall"}, done3, 0);
    k   = 0;
    bad = 0;
    while (k < 200) begin
      @(posedge clk); #1;
      k++;
      if (done3) break;
      if (int'(stim3) != k / 4) bad++;
      if (k == glitch_at) begin
        start3 = 1'b1;
        op3    = 3'd2;
      end else begin
        start3 = 1'b0;
      end
    end
    start3 = 1'b0;
    check({name, "_cycles"},     k, exp_cycles);
    check({name, "_stim_steps"}, bad, 0);
    check({name, "_err"},        err3, exp_err);
    check({name, "_fail_vec"},   fail3, fail_v);
    check({name, "_pass"},       pass3, exp_pass);
    check({name, "_busy_low"},   busy3, 0);
    check({name, "_stim_final"}, stim3, exp_stim);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int m_err;
    int m_fail;
    logic [2:0] r_op;
    logic [7:0] r_tab;

    // op, DUT truth table (bit v = DUT output for vector v), err, fail, pass
    vecs[0] = '{3'd1, 8'hFE, 0, 0, 1'b1};  // OR vs ideal OR
    vecs[1] = '{3'd0, 8'hFE, 6, 1, 1'b0};  // AND vs OR gate
    vecs[2] = '{3'd2, 8'h96, 0, 0, 1'b1};  // XOR vs ideal XOR
    vecs[3] = '{3'd3, 8'h80, 8, 0, 1'b0};  // NAND vs AND gate
    vecs[4] = '{3'd4, 8'h00, 1, 0, 1'b0};  // NOR vs stuck-at-0
    vecs[5] = '{3'd5, 8'hFE, 5, 0, 1'b0};  // XNOR vs OR gate
    vecs[6] = '{3'd7, 8'hFE, 0, 0, 1'b1};  // op 7 behaves as OR
    vecs[7] = '{3'd6, 8'h80, 6, 1, 1'b0};  // op 6 behaves as OR, AND gate

    repeat (2) @(posedge clk);
    #1;
    check("rst_stim",  stim3, 0);
    check("rst_busy",  busy3, 0);
    check("rst_done",  done3, 0);
    check("rst_pass",  pass3, 0);
    check("rst_err",   err3, 0);
    check("rst_fail",  fail3, 0);
    check("rst_other", {busy4, done4, busy1, done1}, 0);
    rst = 1'b0;

    foreach (vecs[i])
      run3($sformatf("vec%0d", i), vecs[i].op, vecs[i].tab, -1,
           vecs[i].err, vecs[i].fail, vecs[i].pass);

    for (int it = 0; it < 12; it++) begin
      r_op  = 3'($urandom_range(0, 7));
      r_tab = 8'($urandom);
      if ($urandom_range(0, 2) == 0)
        for (int v = 0; v < 8; v++) r_tab[v] = ref_gold(int'(r_op), v, 3);
      m_err  = 0;
      m_fail = 0;
      for (int v = 0; v < 8; v++) begin
        if (r_tab[v] != ref_gold(int'(r_op), v, 3)) begin
          if (m_err == 0) m_fail = v;
          m_err++;
        end
      end
      run3($sformatf("rand%0d", it), r_op, r_tab,
           ($urandom_range(0, 1) == 1) ? 2 : -1, m_err, m_fail, m_err == 0);
    end

    // Reset mid-sweep at stim=101 discards the partial results.
    dut_tab3 = 8'hFE;
    @(negedge clk);
    op3    = STOP ? 3'd1 : 3'd0;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    k = 0;
    while (k < 100 && stim3 != 3'd5) begin
      @(posedge clk); #1;
      k++;
    end
    check("mid_reached_101", stim3, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_stim", stim3, 0);
    check("mid_rst_busy", busy3, 0);
    check("mid_rst_err",  err3, 0);
    check("mid_rst_done", done3, 0);
    start3 = 1'b1;
    @(posedge clk); #1;
    check("rst_beats_start", busy3, 0);
    rst    = 1'b0;
    start3 = 1'b0;
    run3("post_rst", 3'd1, 8'hFE, -1, 0, 0, 1'b1);

    // start and op change mid-sweep are ignored; then restart from DONE.
    run3("glitch",      3'd1, 8'hFE, 5, 0, 0, 1'b1);
    run3("restart_nor", 3'd4, 8'h01, -1, 0, 0, 1'b1);

    // HOLD_CYCLES=1, XNOR against stuck-at-0.
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    check("h1_busy_rise", busy4, 1);
    k = 0;
    while (k < 100) begin
      @(posedge clk); #1;
      k++;
      if (done4) break;
    end
    check("h1_cycles", k, STOP ? 1 : 16);
    check("h1_err",    err4, STOP ? 1 : 8);
    check("h1_fail",   fail4, 0);
    check("h1_pass",   pass4, 0);
    check("h1_stim",   stim4, STOP ? 0 : 15);

    // N_IN=1, HOLD=255, NAND against an inverter.
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    k = 0;
    while (k < 600) begin
      @(posedge clk); #1;
      k++;
      if (done1) break;
      if (k == 254) check("n1_stim_hold0", stim1, 0);
      if (k == 255) check("n1_stim_step1", stim1, 1);
    end
    check("n1_cycles", k, 510);
    check("n1_pass",   pass1, 1);
    check("n1_err",    err1, 0);
    check("n1_fail",   fail1, 0);
    check("n1_stim",   stim1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
